// File: rtl/bram_arb_pkg.sv
// Shared types and default sizing for the fetch/data BRAM port arbiter.
package bram_arb_pkg;

    localparam int unsigned AW_DEF       = 12;
    localparam int unsigned MAX_WAIT_DEF = 3;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_D
    } own_t;

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Requester and BRAM-side signal bundle for the BRAM port arbiter.
interface bram_port_arbiter_if
    import bram_arb_pkg::*;
#(
    parameter int unsigned AW = AW_DEF
);
    logic          if_req;
    logic [31:0]   if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [31:0]   if_rdata;

    logic          d_req;
    logic          d_we;
    logic [3:0]    d_be;
    logic [31:0]   d_addr;
    logic [31:0]   d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [31:0]   d_rdata;

    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    logic          stall_f;
    logic          stall_m;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, stall_f, stall_m
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, stall_f, stall_m
    );

endinterface

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive cycles fetch lost arbitration; raises force_if at the limit.
module arb_starve_ctr #(
    parameter int unsigned MAX_WAIT = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic force_if
);

    localparam int unsigned CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CW'(MAX_WAIT))) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_if = (cnt_q == CW'(MAX_WAIT));

endmodule

// File: rtl/bram_port_arbiter.sv
// Single-port BRAM shared by fetch and memory stage: data-priority grant with
// bounded fetch starvation, one-cycle read data steered back by response owner.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned AW       = AW_DEF,
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
    input logic                clk,
    input logic                reset,
    bram_port_arbiter_if.slave bus
);

    logic        force_if;
    logic        if_gnt_c;
    logic        d_gnt_c;
    logic [31:0] sel_addr;
    own_t        rsp_own_q;
    own_t        rsp_own_d;
    logic        unused_sel_bits;

    arb_starve_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_ctr (
        .clk      (clk),
        .reset    (reset),
        .inc      (bus.if_req & d_gnt_c),
        .clr      (if_gnt_c | ~bus.if_req),
        .force_if (force_if)
    );

    // Data wins unless fetch has starved long enough to be forced through.
    always_comb begin
        if_gnt_c = 1'b0;
        d_gnt_c  = 1'b0;
        if (reset) begin
            if (bus.d_req && !(bus.if_req && force_if)) begin
                d_gnt_c = 1'b1;
            end else if (bus.if_req) begin
                if_gnt_c = 1'b1;
            end
        end
    end

    always_comb begin
        sel_addr      = if_gnt_c ? bus.if_addr : bus.d_addr;
        bus.mem_en    = if_gnt_c | d_gnt_c;
        bus.mem_addr  = sel_addr[AW+1:2];
        bus.mem_we    = (d_gnt_c && bus.d_we) ? bus.d_be : 4'b0000;
        bus.mem_wdata = bus.d_wdata;
    end

    assign unused_sel_bits = ^{sel_addr[31:AW+2], sel_addr[1:0]};

    always_comb begin
        rsp_own_d = OWN_NONE;
        if (if_gnt_c) begin
            rsp_own_d = OWN_IF;
        end else if (d_gnt_c && !bus.d_we) begin
            rsp_own_d = OWN_D;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rsp_own_q <= OWN_NONE;
        end else begin
            rsp_own_q <= rsp_own_d;
        end
    end

    // Gating with reset drops a read granted just before reset asserts.
    assign bus.if_rvalid = reset && (rsp_own_q == OWN_IF);
    assign bus.d_rvalid  = reset && (rsp_own_q == OWN_D);
    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.d_rdata   = bus.mem_rdata;
    assign bus.if_gnt    = if_gnt_c;
    assign bus.d_gnt     = d_gnt_c;
    assign bus.stall_f   = bus.if_req & ~if_gnt_c;
    assign bus.stall_m   = bus.d_req & ~d_gnt_c;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Randomized and directed bench for bram_port_arbiter against a behavioural arbitration/memory model.
module tb_bram_port_arbiter;

    localparam int unsigned AW    = 12;
    localparam int unsigned MW    = 3;
    localparam int unsigned DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bram_port_arbiter_if #(.AW(AW)) bus ();

    bram_port_arbiter #(
        .AW       (AW),
        .MAX_WAIT (MW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] bram    [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] rd_q;

    int          n_checks;
    int          n_fail;
    int          losses;
    int          own;
    logic [31:0] own_data;
    logic        prev_if_gnt;
    logic        prev_d_gnt;
    logic [31:0] old_w;

    assign bus.mem_rdata = rd_q;

    // BRAM: one-cycle read latency, byte-enabled writes
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we == 4'b0000) begin
                rd_q <= bram[bus.mem_addr];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.mem_we[b]) bram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        if ($urandom_range(0, 3) == 0) a = $urandom;
        else a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
        return a;
    endfunction

    // One clock: check DUT against the model mid-cycle, then advance the model.
    task automatic cycle();
        logic          eg_if;
        logic          eg_d;
        logic          e_en;
        logic [3:0]    e_we;
        logic [AW-1:0] e_addr;
        logic [31:0]   a;
        @(negedge clk);
        eg_if = 1'b0;
        eg_d  = 1'b0;
        if (reset) begin
            if (bus.if_req && bus.d_req) begin
                if (losses >= int'(MW)) eg_if = 1'b1;
                else eg_d = 1'b1;
            end else begin
                eg_if = bus.if_req;
                eg_d  = bus.d_req;
            end
        end
        e_en   = eg_if | eg_d;
        a      = eg_if ? bus.if_addr : bus.d_addr;
        e_addr = AW'(a >> 2);
        e_we   = (eg_d && bus.d_we) ? bus.d_be : 4'b0000;

        check("if_gnt",   32'(bus.if_gnt),  32'(eg_if));
        check("d_gnt",    32'(bus.d_gnt),   32'(eg_d));
        check("stall_f",  32'(bus.stall_f), 32'(bus.if_req & ~eg_if));
        check("stall_m",  32'(bus.stall_m), 32'(bus.d_req & ~eg_d));
        check("mem_en",   32'(bus.mem_en),  32'(e_en));
        check("mem_we",   32'(bus.mem_we),  32'(e_we));
        if (e_en) begin
            check("mem_addr",  32'(bus.mem_addr), 32'(e_addr));
            check("mem_wdata", bus.mem_wdata,     bus.d_wdata);
        end
        check("if_rvalid", 32'(bus.if_rvalid), 32'(reset && own == 1));
        check("d_rvalid",  32'(bus.d_rvalid),  32'(reset && own == 2));
        if (reset && own == 1) check("if_rdata", bus.if_rdata, own_data);
        if (reset && own == 2) check("d_rdata",  bus.d_rdata,  own_data);

        if (!reset) begin
            losses = 0;
            own    = 0;
        end else begin
            if (eg_if || !bus.if_req) losses = 0;
            else if (eg_d && losses < int'(MW)) losses++;
            own = 0;
            if (eg_if || (eg_d && !bus.d_we)) begin
                own      = eg_if ? 1 : 2;
                own_data = ref_mem[e_addr];
            end else if (eg_d) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.d_be[b]) ref_mem[e_addr][8*b +: 8] = bus.d_wdata[8*b +: 8];
                end
            end
        end
        prev_if_gnt = eg_if;
        prev_d_gnt  = eg_d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        losses   = 0;
        own      = 0;
        own_data = '0;
        rd_q     = '0;
        prev_if_gnt = 1'b0;
        prev_d_gnt  = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            bram[i]    = $urandom;
            ref_mem[i] = bram[i];
        end
        reset       = 1'b0;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h10;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_be    = 4'b0000;
        bus.d_addr  = 32'h20;
        bus.d_wdata = '0;
        @(posedge clk);
        #1;
        check("rst_mem_en", 32'(bus.mem_en), 32'd0);
        check("rst_if_gnt", 32'(bus.if_gnt), 32'd0);
        check("rst_d_gnt",  32'(bus.d_gnt),  32'd0);
        cycle();
        cycle();
        reset      = 1'b1;
        bus.d_req  = 1'b0;
        bus.if_req = 1'b0;
        cycle();

        // fetch only, consecutive words
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h10;
        #1 check("fo_addr0", 32'(bus.mem_addr), 32'd4);
        cycle();
        bus.if_addr = 32'h14;
        #1 check("fo_addr1", 32'(bus.mem_addr), 32'd5);
        check("fo_rdata0", bus.if_rdata, ref_mem[4]);
        cycle();
        bus.if_req = 1'b0;
        #1 check("fo_rdata1", bus.if_rdata, ref_mem[5]);
        cycle();

        // contention: three data wins, then forced fetch
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h40;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h80;
        for (int k = 0; k < 5; k++) begin
            #1 check("ct_d_gnt",   32'(bus.d_gnt),   32'(k != 3));
            check("ct_stall_m", 32'(bus.stall_m), 32'(k == 3));
            cycle();
            if (k == 3) bus.if_req = 1'b0;
        end
        bus.d_req = 1'b0;
        cycle();

        // partial store then load of same word
        old_w       = ref_mem[8];
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_be    = 4'b0011;
        bus.d_addr  = 32'h20;
        bus.d_wdata = 32'hAABBCCDD;
        #1 check("st_we", 32'(bus.mem_we), 32'h3);
        check("st_addr", 32'(bus.mem_addr), 32'd8);
        cycle();
        bus.d_we = 1'b0;
        #1 check("st_no_rvalid", 32'(bus.d_rvalid), 32'd0);
        cycle();
        bus.d_req = 1'b0;
        #1 check("ld_after_st", bus.d_rdata, {old_w[31:16], 16'hCCDD});
        cycle();

        // load granted, then reset: response dropped
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h30;
        cycle();
        reset = 1'b0;
        #1 check("rst_drop_rvalid", 32'(bus.d_rvalid), 32'd0);
        check("rst_drop_en", 32'(bus.mem_en), 32'd0);
        cycle();
        reset     = 1'b1;
        bus.d_req = 1'b0;
        cycle();

        // address wrap
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h4000;
        #1 check("wrap_addr", 32'(bus.mem_addr), 32'd0);
        cycle();
        bus.if_req = 1'b0;
        cycle();

        // fetch drops mid-starvation: counter restarts
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h44;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h84;
        cycle();
        cycle();
        bus.if_req = 1'b0;
        cycle();
        bus.if_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1 check("dr_if_gnt", 32'(bus.if_gnt), 32'(k == 3));
            cycle();
        end
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        cycle();

        // randomized traffic, requesters hold while stalled (with rare drops)
        for (int n = 0; n < 3000; n++) begin
            if (!(bus.if_req && !prev_if_gnt) || $urandom_range(0, 19) == 0) begin
                bus.if_req  = ($urandom_range(0, 2) != 0);
                bus.if_addr = rnd_addr();
            end
            if (!(bus.d_req && !prev_d_gnt)) begin
                bus.d_req   = ($urandom_range(0, 2) != 0);
                bus.d_we    = ($urandom_range(0, 2) == 0);
                bus.d_be    = 4'($urandom_range(1, 15));
                bus.d_addr  = rnd_addr();
                bus.d_wdata = $urandom;
            end
            reset = ($urandom_range(0, 99) != 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Shares the single-port instruction/data BRAM between the fetch stage and the memory stage of the pipelined core. Arbitrates one access per cycle, steers the one-cycle-latency BRAM read data back to the winning requester, and produces the stall terms the hazard unit folds into StallF/StallD and the M-stage hold. Data-side priority by default, with a bounded-starvation override so fetch always makes progress.

## Interface
Parameters:
- AW, 12, BRAM word-address width (depth = 2**AW words of 32 bits)
- MAX_WAIT, 3, consecutive cycles fetch may lose arbitration before it is forced to win (≥1)

Ports:
- clk  in  1  core clock; all state on rising edge
- reset  in  1  synchronous, active-low reset (sampled on clk; 0 = reset)
- if_req  in  1  fetch requests a read this cycle
- if_addr  in  32  fetch byte address (PCF); bits [1:0] ignored
- if_gnt  out  1  fetch access issued to BRAM this cycle
- if_rvalid  out  1  if_rdata valid (cycle after if_gnt)
- if_rdata  out  32  instruction word
- d_req  in  1  memory stage requests an access
- d_we  in  1  1 = store, 0 = load
- d_be  in  4  store byte enables
- d_addr  in  32  data byte address (ALUResultM); bits [1:0] ignored
- d_wdata  in  32  store data (WriteDataM, already lane-aligned)
- d_gnt  out  1  data access issued this cycle
- d_rvalid  out  1  d_rdata valid (cycle after a load grant)
- d_rdata  out  32  raw load word (sign/byte extraction done downstream)
- mem_en  out  1  BRAM enable
- mem_we  out  4  BRAM byte write enables
- mem_addr  out  AW  BRAM word address
- mem_wdata  out  32  BRAM write data
- mem_rdata  in  32  BRAM read data, valid one cycle after mem_en with mem_we=0
- stall_f  out  1  if_req & ~if_gnt
- stall_m  out  1  d_req & ~d_gnt

## Operation
- Grant (combinational from current inputs and state):
  - only one requester → it wins.
  - both, wait_cnt < MAX_WAIT → data wins.
  - both, wait_cnt == MAX_WAIT → fetch wins.
  - reset low → no grants, mem_en=0.
- Issued access: mem_en=1; mem_addr = winner addr[AW+1:2] (upper bits dropped, wrap modulo depth); mem_we = d_be if data store else 4'b0; mem_wdata = d_wdata.
- wait_cnt (0..MAX_WAIT, saturating): +1 when if_req & d_gnt; cleared when if_gnt or ~if_req.
- Response owner register rsp_own ∈ {NONE, IF, D}: IF on fetch grant, D on load grant, NONE on store grant or idle.
- if_rvalid = (rsp_own==IF); d_rvalid = (rsp_own==D); both rdata outputs driven from mem_rdata (unqualified data ignored by consumers).
- Stores never produce rvalid.

## Timing
- Grant latency 0 cycles; read data latency 1 cycle after grant; throughput one access/cycle.
- Back-to-back grants to alternating owners legal; rsp_own updates every cycle.
- Reset (reset=0 sampled): rsp_own=NONE, wait_cnt=0 → if_rvalid=d_rvalid=0 next cycle; if_gnt=d_gnt=mem_en=0, mem_we=0 while reset low. A read granted the cycle before reset is discarded (no rvalid).
- Simultaneous store and fetch under priority: store writes, fetch stalls; fetch reading the same word next cycle sees new data (BRAM read-first/write-first irrelevant, different cycles).
- Requesters hold req/addr stable while stalled; arbiter is stateless with respect to addresses.

## Structure
- Package bram_arb_pkg: typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} own_t; default AW/MAX_WAIT localparams.
- One sub-module: arb_starve_ctr (saturating wait counter, outputs force_if = cnt==MAX_WAIT).
- Top: grant logic, BRAM mux, rsp_own register.

## Test plan
- Fetch only, if_addr=0x10, 0x14 consecutive → if_gnt=1 both cycles, mem_addr=4,5, if_rvalid next cycle with preloaded words.
- Load and fetch together, MAX_WAIT=3 → d_gnt cycles 1-3, stall_f=1 cycles 1-3, cycle 4 if_gnt=1 and stall_m=1, wait_cnt back to 0.
- Store d_addr=0x20, d_be=4'b0011, d_wdata=0xAABBCCDD → mem_we=0011, mem_addr=8, no d_rvalid; subsequent load returns 0x????CCDD lanes updated.
- Load granted, reset=0 next edge → d_rvalid stays 0, all grants 0 during reset, wait_cnt=0 after release.
- Address 0x4000 with AW=12 → mem_addr=0 (wrap).
- Fetch request drops mid-starvation (cnt=2) → counter clears; next contention needs 3 more data wins before forced fetch grant.
